midi_msg_parser: RTL and testbench
==================================

Name: midi_msg_parser

Overview:
- Sequences the raw byte stream from the MIDI UART receiver into complete MIDI messages.
- Tracks message boundaries and running status, passes real-time bytes straight through, and discards SysEx payloads.
- Buffers completed messages in a small FIFO and presents them on a valid/ready interface to the MMIO register block or CPU-side consumer.
- Sits between the UART receiver (byte + done strobe) and the MIDI MMIO peripheral.

Parameters:
- FIFO_DEPTH, 4, message FIFO entries; power of 2, minimum 2.
- REALTIME_EN, 1, 1 = forward real-time bytes 0xF8–0xFF as 0-data messages; 0 = drop them silently.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset
- byte_valid_i  in  1  one-cycle strobe, new received byte (UART done strobe)
- byte_i  in  8  received byte, valid with byte_valid_i
- msg_valid_o  out  1  FIFO head holds a message
- msg_ready_i  in  1  consumer accepts head when msg_valid_o & msg_ready_i
- msg_status_o  out  8  status byte of head message
- msg_data1_o  out  7  first data byte (0 if unused)
- msg_data2_o  out  7  second data byte (0 if unused)
- msg_len_o  out  2  data byte count, 0..2
- overflow_o  out  1  one-cycle pulse: completed message dropped, FIFO full
- err_o  out  1  one-cycle pulse: orphan data byte or undefined status 0xF4/0xF5/stray 0xF7

Interface rules:
- One clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset state: every output 0, FIFO empty, parser in Idle, running status cleared.

Behaviour:
- Byte classes:
  - bit7 = 1: status byte.
  - 0xF8–0xFF: real-time.
  - bit7 = 0: data byte.
- Data length by status:
  - 0x8n, 0x9n, 0xAn, 0xBn, 0xEn, 0xF2: 2 data bytes.
  - 0xCn, 0xDn, 0xF1, 0xF3: 1 data byte.
  - 0xF6: 0 data bytes.
- States: Idle, WaitD1, WaitD2, SysEx. Registers: run_status (8), d1 (7).
- Real-time byte, in any state:
  - Does not change state, run_status or d1.
  - If REALTIME_EN, pushes {status=byte, len=0}.
- Idle:
  - Channel or system-common status: latch run_status. Go to WaitD1 if len ≥ 1. For 0xF6, push immediately and stay in Idle.
  - 0xF0: go to SysEx.
  - Data byte: if run_status is a valid channel status, treat as D1 (running status). Otherwise discard and pulse err_o.
- WaitD1, data byte:
  - len = 1: push message, then go to Idle (channel status keeps run_status; system common clears it).
  - len = 2: store d1, go to WaitD2.
- WaitD2, data byte: push {run_status, d1, byte, 2} and go to Idle with run_status kept.
- Any new non-real-time status in WaitD1/WaitD2 aborts the partial message (no err_o) and is processed as in Idle.
- SysEx:
  - Discard data bytes.
  - 0xF7: go to Idle with run_status cleared.
  - Any other non-real-time status: ends SysEx and is processed as in Idle.
- 0xF4, 0xF5, or 0xF7 outside SysEx: clear run_status, go to Idle, pulse err_o.
- Timing:
  - Push occurs on the clock edge after the cycle with the completing byte_valid_i; msg_valid_o is high the next cycle.
  - byte_valid_i at cycle N → msg_valid_o at N+1.
  - err_o and overflow_o are registered and pulse at N+1.
- FIFO:
  - First-word fall-through; outputs come straight from registers.
  - Pop when msg_valid_o & msg_ready_i.
  - Push when full is accepted only if a pop occurs the same cycle. Otherwise the message is dropped and overflow_o pulses; parser state still advances.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Outputs must hold stable while msg_valid_o=1 and msg_ready_i=0.
- Back-to-back byte_valid_i on consecutive cycles must be handled.
- Reset asserted mid-message clears everything; no partial message survives.

Decomposition:
- Shared package midi_pkg:
  - midi_parse_state_t (Idle/WaitD1/WaitD2/SysEx).
  - Status constants: SYSEX_START=0xF0, SYSEX_END=0xF7, TUNE_REQ=0xF6, RT_BASE=0xF8.
  - midi_msg_t struct {status, d1, d2, len}.
  - Function midi_data_len(status) returning 0..2.
- Sub-module: msg_fifo, a generic FWFT synchronous FIFO, width = $bits(midi_msg_t), depth FIFO_DEPTH, full/empty outputs.

Test Plan:
- Note-on 0x90,0x3C,0x64 with msg_ready_i=1 → one message: status 0x90, d1 0x3C, d2 0x64, len 2; msg_valid_o one cycle after the third strobe.
- Running status: 0x90,0x3C,0x64,0x3E,0x00 → two messages, the second with status 0x90, d1 0x3E, d2 0x00.
- Real-time interleave: 0x90,0x3C,0xF8,0x64 → message F8/len 0 first, then the 0x90 note-on intact. Same stimulus with REALTIME_EN=0 → only the note-on.
- SysEx: 0xF0,0x7E,0x01,0xF7, then 0xC5,0x10 → only program change 0xC5, d1 0x10, len 1. A following lone 0x20 → err_o pulse, no message.
- Overflow: msg_ready_i=0, five 0xC0,0x0n messages with FIFO_DEPTH=4 → four stored, overflow_o pulses once. Then with msg_ready_i=1 → n=0..3 pop in order.
- Reset mid-message: 0x90,0x3C, assert rst_ni low, release, send 0x40 → err_o pulse, FIFO empty, no message.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared types and helpers for the MIDI message parser and its message FIFO.
// A message is a status byte plus up to two 7-bit data bytes and a data count.
package midi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SYSEX   = 2'd3
  } midi_parse_state_t;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] TUNE_REQ    = 8'hF6;
  localparam logic [7:0] RT_BASE     = 8'hF8;
  localparam logic [7:0] UNDEF_F4    = 8'hF4;
  localparam logic [7:0] UNDEF_F5    = 8'hF5;

  typedef struct packed {
    logic [7:0] status;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [1:0] len;
  } midi_msg_t;

  localparam int MSG_W = $bits(midi_msg_t);

  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hC, 4'hD:                   len = 2'd1;
      4'hF: begin
        case (status)
          8'hF2:        len = 2'd2;
          8'hF1, 8'hF3: len = 2'd1;
          default:      len = 2'd0;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

  function automatic logic is_channel_status(input logic [7:0] status);
    return status[7] && (status[7:4] != 4'hF);
  endfunction

endpackage

// File: rtl/midi_msg_parser_fifo.sv
// Generic first-word-fall-through FIFO; head is a mux over the storage registers.
// Pointers carry one extra wrap bit to tell full from empty.
module msg_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = pop_i && !w_empty;
  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign w_push  = push_i && (!w_full || w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
  end

  assign data_o  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule

// File: rtl/midi_msg_parser.sv
// Turns the UART byte stream into complete MIDI messages (running status,
// real-time pass-through, SysEx discard) and queues them for the consumer.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter bit REALTIME_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       msg_valid_o,
  input  logic       msg_ready_i,
  output logic [7:0] msg_status_o,
  output logic [6:0] msg_data1_o,
  output logic [6:0] msg_data2_o,
  output logic [1:0] msg_len_o,
  output logic       overflow_o,
  output logic       err_o
);

  midi_parse_state_t r_state, w_state_nxt;
  logic [7:0]        r_run_status, w_run_nxt;
  logic [6:0]        r_d1, w_d1_nxt;
  logic              r_err, r_overflow;

  logic              w_push;
  midi_msg_t         w_push_msg;
  logic              w_err;
  logic [1:0]        w_run_len;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [MSG_W-1:0]  w_head;
  midi_msg_t         w_head_msg;

  assign w_run_len = midi_data_len(r_run_status);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_run_status <= 8'h00;
      r_d1         <= 7'h00;
      r_err        <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_run_status <= w_run_nxt;
      r_d1         <= w_d1_nxt;
      r_err        <= w_err;
      r_overflow   <= w_push && w_full && !w_pop;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run_status;
    w_d1_nxt    = r_d1;
    w_push      = 1'b0;
    w_push_msg  = '0;
    w_err       = 1'b0;

    if (byte_valid_i) begin
      if (byte_i >= RT_BASE) begin
        // Real-time bytes never disturb the message being assembled.
        if (REALTIME_EN) begin
          w_push            = 1'b1;
          w_push_msg.status = byte_i;
        end
      end else if (byte_i[7]) begin
        if ((r_state == ST_SYSEX) && (byte_i == SYSEX_END)) begin
          w_state_nxt = ST_IDLE;
          w_run_nxt   = 8'h00;
        end else if ((byte_i == SYSEX_END) || (byte_i == UNDEF_F4) ||
                     (byte_i == UNDEF_F5)) begin
          w_state_nxt = ST_IDLE;
          w_run_nxt   = 8'h00;
          w_err       = 1'b1;
        end else if (byte_i == SYSEX_START) begin
          w_state_nxt = ST_SYSEX;
        end else if (byte_i == TUNE_REQ) begin
          w_state_nxt       = ST_IDLE;
          w_run_nxt         = byte_i;
          w_push            = 1'b1;
          w_push_msg.status = byte_i;
        end else begin
          w_state_nxt = ST_WAIT_D1;
          w_run_nxt   = byte_i;
        end
      end else begin
        case (r_state)
          ST_IDLE, ST_WAIT_D1: begin
            if ((r_state == ST_IDLE) && !is_channel_status(r_run_status)) begin
              w_err = 1'b1;
            end else if (w_run_len == 2'd1) begin
              w_push      = 1'b1;
              w_push_msg  = {r_run_status, byte_i[6:0], 7'h00, 2'd1};
              w_state_nxt = ST_IDLE;
              if (!is_channel_status(r_run_status)) w_run_nxt = 8'h00;
            end else begin
              w_d1_nxt    = byte_i[6:0];
              w_state_nxt = ST_WAIT_D2;
            end
          end
          ST_WAIT_D2: begin
            w_push      = 1'b1;
            w_push_msg  = {r_run_status, r_d1, byte_i[6:0], 2'd2};
            w_state_nxt = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_pop = !w_empty && msg_ready_i;

  msg_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_push_msg),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign w_head_msg   = midi_msg_t'(w_head);
  assign msg_valid_o  = !w_empty;
  assign msg_status_o = w_head_msg.status;
  assign msg_data1_o  = w_head_msg.d1;
  assign msg_data2_o  = w_head_msg.d2;
  assign msg_len_o    = w_head_msg.len;
  assign overflow_o   = r_overflow;
  assign err_o        = r_err;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench: one parser with real-time forwarding, one without, fed the
// same byte stream; a negedge monitor records every accepted message.
module tb_midi_msg_parser;
  import midi_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       byte_valid_i = 1'b0;
  logic [7:0] byte_i = 8'h00;
  logic       msg_ready_i = 1'b0;
  logic       msg_valid_o, overflow_o, err_o;
  logic [7:0] msg_status_o;
  logic [6:0] msg_data1_o, msg_data2_o;
  logic [1:0] msg_len_o;

  logic       ready_b = 1'b1;
  logic       valid_b, overflow_b, err_b;
  logic [7:0] status_b;
  logic [6:0] data1_b, data2_b;
  logic [1:0] len_b;

  midi_msg_parser #(.FIFO_DEPTH(4), .REALTIME_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
    .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i), .msg_status_o(msg_status_o),
    .msg_data1_o(msg_data1_o), .msg_data2_o(msg_data2_o), .msg_len_o(msg_len_o),
    .overflow_o(overflow_o), .err_o(err_o)
  );

  midi_msg_parser #(.FIFO_DEPTH(4), .REALTIME_EN(1'b0)) dut_nort (
    .clk_i(clk_i), .rst_ni(rst_ni), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
    .msg_valid_o(valid_b), .msg_ready_i(ready_b), .msg_status_o(status_b),
    .msg_data1_o(data1_b), .msg_data2_o(data2_b), .msg_len_o(len_b),
    .overflow_o(overflow_b), .err_o(err_b)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  midi_msg_t q[$];
  midi_msg_t q_b[$];

  always @(negedge clk_i) begin
    if (msg_valid_o && msg_ready_i) q.push_back({msg_status_o, msg_data1_o, msg_data2_o, msg_len_o});
    if (valid_b && ready_b) q_b.push_back({status_b, data1_b, data2_b, len_b});
    if (err_o) err_cnt++;
    if (overflow_o) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int idx, input midi_msg_t exp);
    if (idx < q.size()) chk(tag, 32'(q[idx]), 32'(exp));
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk_i); #1;
    byte_valid_i = 1'b1;
    byte_i       = b;
  endtask

  task automatic idle(input int n);
    @(posedge clk_i); #1;
    byte_valid_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  int b0, bb0, e0, o0;

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(msg_valid_o), 0);
    chk("rst_status", 32'(msg_status_o), 0);
    chk("rst_len", 32'(msg_len_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    rst_ni = 1'b1;
    msg_ready_i = 1'b1;

    // note-on with latency check
    b0 = q.size();
    send(8'h90); send(8'h3C); send(8'h64);
    @(negedge clk_i);
    chk("non_valid_early", 32'(msg_valid_o), 0);
    @(posedge clk_i); #1;
    byte_valid_i = 1'b0;
    @(negedge clk_i);
    chk("non_valid_n1", 32'(msg_valid_o), 1);
    idle(3);
    chk("non_cnt", 32'(q.size() - b0), 1);
    chk_q("non_msg", b0, {8'h90, 7'h3C, 7'h64, 2'd2});

    // running status
    b0 = q.size();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h00);
    idle(3);
    chk("run_cnt", 32'(q.size() - b0), 2);
    chk_q("run_msg0", b0, {8'h90, 7'h3C, 7'h64, 2'd2});
    chk_q("run_msg1", b0 + 1, {8'h90, 7'h3E, 7'h00, 2'd2});

    // real-time interleave
    b0 = q.size(); bb0 = q_b.size();
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    idle(3);
    chk("rt_cnt", 32'(q.size() - b0), 2);
    chk_q("rt_msg0", b0, {8'hF8, 7'h00, 7'h00, 2'd0});
    chk_q("rt_msg1", b0 + 1, {8'h90, 7'h3C, 7'h64, 2'd2});
    chk("rt_off_cnt", 32'(q_b.size() - bb0), 1);
    if (bb0 < q_b.size()) chk("rt_off_msg", 32'(q_b[bb0]), 32'({8'h90, 7'h3C, 7'h64, 2'd2}));

    // SysEx discard then program change; orphan data after SysEx end
    b0 = q.size(); e0 = err_cnt;
    send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'hC5); send(8'h10);
    idle(3);
    chk("sx_cnt", 32'(q.size() - b0), 1);
    chk_q("sx_pc", b0, {8'hC5, 7'h10, 7'h00, 2'd1});
    chk("sx_err_none", 32'(err_cnt - e0), 0);
    b0 = q.size();
    send(8'hF0); send(8'h01); send(8'hF7); send(8'h20);
    idle(3);
    chk("orphan_err", 32'(err_cnt - e0), 1);
    chk("orphan_cnt", 32'(q.size() - b0), 0);

    // tune request and undefined status
    b0 = q.size(); e0 = err_cnt;
    send(8'hF6); send(8'hF4);
    idle(3);
    chk("tune_cnt", 32'(q.size() - b0), 1);
    chk_q("tune_msg", b0, {8'hF6, 7'h00, 7'h00, 2'd0});
    chk("f4_err", 32'(err_cnt - e0), 1);

    // overflow: five messages into a 4-deep FIFO with consumer stalled
    msg_ready_i = 1'b0;
    b0 = q.size(); o0 = ovf_cnt;
    for (int i = 0; i < 5; i++) begin
      send(8'hC0); send(8'(i));
    end
    idle(3);
    chk("ovf_pulses", 32'(ovf_cnt - o0), 1);
    chk("ovf_valid", 32'(msg_valid_o), 1);
    chk("ovf_head", {8'h00, msg_status_o, msg_data1_o, msg_data2_o, msg_len_o},
        32'({8'hC0, 7'h00, 7'h00, 2'd1}));
    repeat (3) @(posedge clk_i);
    #1;
    chk("ovf_head_stable", {8'h00, msg_status_o, msg_data1_o, msg_data2_o, msg_len_o},
        32'({8'hC0, 7'h00, 7'h00, 2'd1}));
    msg_ready_i = 1'b1;
    idle(6);
    chk("ovf_drain_cnt", 32'(q.size() - b0), 4);
    for (int i = 0; i < 4; i++)
      chk_q($sformatf("ovf_drain%0d", i), b0 + i, {8'hC0, 7'(i), 7'h00, 2'd1});
    chk("ovf_empty", 32'(msg_valid_o), 0);

    // push into a full FIFO on the same cycle as a pop is kept
    msg_ready_i = 1'b0;
    b0 = q.size(); o0 = ovf_cnt;
    for (int i = 0; i < 4; i++) begin
      send(8'hC0); send(8'(i));
    end
    send(8'hC0);
    @(posedge clk_i); #1;
    byte_i = 8'h04;
    msg_ready_i = 1'b1;
    idle(8);
    chk("fullpop_ovf", 32'(ovf_cnt - o0), 0);
    chk("fullpop_cnt", 32'(q.size() - b0), 5);
    for (int i = 0; i < 5; i++)
      chk_q($sformatf("fullpop%0d", i), b0 + i, {8'hC0, 7'(i), 7'h00, 2'd1});

    // reset mid-message
    send(8'h90); send(8'h3C);
    @(posedge clk_i); #1;
    byte_valid_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    b0 = q.size(); e0 = err_cnt;
    send(8'h40);
    idle(3);
    chk("rstmid_err", 32'(err_cnt - e0), 1);
    chk("rstmid_cnt", 32'(q.size() - b0), 0);
    chk("rstmid_valid", 32'(msg_valid_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
